// File: rtl/addsub_4bit_if.sv
// Operand/result bundle for the 4-bit add/subtract slice.
//
// Handshake: there is no back-pressure. The producer asserts in_valid for
// one cycle per operation with a/b/sub stable around the rising edge. The
// slice answers exactly one cycle later with out_valid high for one cycle.
// When out_valid is low, sum and the flags keep the last accepted result.
interface addsub_4bit_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       sub;
  logic       in_valid;
  logic [3:0] sum;
  logic       ovfl;
  logic       carry_out;
  logic       zero;
  logic       neg;
  logic       out_valid;

  modport master (
    output a, b, sub, in_valid,
    input  sum, ovfl, carry_out, zero, neg, out_valid
  );

  modport slave (
    input  a, b, sub, in_valid,
    output sum, ovfl, carry_out, zero, neg, out_valid
  );
endinterface

// File: rtl/addsub_4bit.sv
// Registered 4-bit two's-complement adder/subtractor. One ripple-carry chain
// with B-inversion: subtract is a + ~b + 1, the +1 entering as carry-in.
// Result and flags are registered with one cycle of latency.
module addsub_4bit (
  input  logic               clk,
  input  logic               rst,
  addsub_4bit_if.slave       bus
);

  logic [3:0] w_bx;
  logic [3:0] w_s;
  logic       w_c1;
  logic       w_c2;
  logic       w_c3;
  logic       w_c4;
  logic       w_ovfl;

  logic [3:0] r_sum;
  logic       r_ovfl;
  logic       r_carry_out;
  logic       r_zero;
  logic       r_neg;
  logic       r_out_valid;

  // Conditionally inverted B operand; sub also serves as the carry-in.
  assign w_bx = bus.b ^ {4{bus.sub}};

  // Ripple-carry chain, one full adder per bit, written out so each carry
  // is its own net.
  assign w_s[0] = bus.a[0] ^ w_bx[0] ^ bus.sub;
  assign w_c1   = (bus.a[0] & w_bx[0]) | (bus.a[0] & bus.sub) | (w_bx[0] & bus.sub);
  assign w_s[1] = bus.a[1] ^ w_bx[1] ^ w_c1;
  assign w_c2   = (bus.a[1] & w_bx[1]) | (bus.a[1] & w_c1) | (w_bx[1] & w_c1);
  assign w_s[2] = bus.a[2] ^ w_bx[2] ^ w_c2;
  assign w_c3   = (bus.a[2] & w_bx[2]) | (bus.a[2] & w_c2) | (w_bx[2] & w_c2);
  assign w_s[3] = bus.a[3] ^ w_bx[3] ^ w_c3;
  assign w_c4   = (bus.a[3] & w_bx[3]) | (bus.a[3] & w_c3) | (w_bx[3] & w_c3);

  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  // This also covers subtracting -8, where ~b+1 itself is not representable.
  assign w_ovfl = w_c3 ^ w_c4;

  // Result/flag register: load on in_valid, otherwise hold; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum       <= 4'b0000;
      r_ovfl      <= 1'b0;
      r_carry_out <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
    end else if (bus.in_valid) begin
      r_sum       <= w_s;
      r_ovfl      <= w_ovfl;
      r_carry_out <= w_c4;
      r_zero      <= (w_s == 4'b0000);
      r_neg       <= w_s[3];
    end
  end

  // Valid strobe: a one-cycle-delayed copy of in_valid, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
    end
  end

  assign bus.sum       = r_sum;
  assign bus.ovfl      = r_ovfl;
  assign bus.carry_out = r_carry_out;
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_addsub_4bit.sv
// Bench for addsub_4bit: a driver task applies one operation per cycle and
// pushes the model's answer when the DUT samples it; a negedge monitor pops
// and compares one cycle later, and checks hold behaviour on idle cycles.
module tb_addsub_4bit;

  logic clk;
  logic rst;
  addsub_4bit_if bus ();

  addsub_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected packing: {sum[3:0], ovfl, carry_out, zero, neg}
  logic [7:0] exp_q[$];
  logic [7:0] last_exp;
  logic       mon_en;
  int         n_vec;
  int         n_err;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = 4'd0;
    bus.b        = 4'd0;
    bus.sub      = 1'b0;
    mon_en       = 1'b0;
    last_exp     = 8'h00;
    n_vec        = 0;
    n_err        = 0;
  end

  // ---------------- check / model ----------------
  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input logic s);
    int         sa;
    int         sb;
    int         r;
    logic [3:0] res;
    logic [4:0] wide;
    logic       ov;
    sa   = a[3] ? int'(a) - 16 : int'(a);
    sb   = b[3] ? int'(b) - 16 : int'(b);
    r    = s ? sa - sb : sa + sb;
    ov   = (r > 7) || (r < -8);
    res  = r[3:0];
    wide = {1'b0, a} + {1'b0, b ^ {4{s}}} + {4'b0000, s};
    return {res, ov, wide[4], (res == 4'b0000), res[3]};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic s);
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      last_exp = 8'h00;
      mon_en   = 1'b1;
    end else if (v) begin
      exp_q.push_back(model(a, b, s));
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check_val("out_valid", {7'd0, bus.out_valid}, 8'd1);
        check_val("result", {bus.sum, bus.ovfl, bus.carry_out, bus.zero, bus.neg}, e);
        last_exp = e;
      end else begin
        check_val("idle_valid", {7'd0, bus.out_valid}, 8'd0);
        check_val("hold", {bus.sum, bus.ovfl, bus.carry_out, bus.zero, bus.neg}, last_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset for two cycles with a live-looking operation on the bus.
    drive(1'b1, 1'b1, 4'd5, 4'd2, 1'b0);
    drive(1'b1, 1'b1, 4'd5, 4'd2, 1'b0);
    drive(1'b0, 1'b0, 4'd5, 4'd2, 1'b0);

    // Directed cases.
    drive(1'b0, 1'b1, 4'b0011, 4'b0010, 1'b0);   // 3+2
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    drive(1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0);   // 7+1 overflow
    drive(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0);   // -1 + -1
    drive(1'b0, 1'b1, 4'b0011, 4'b0101, 1'b1);   // 3-5 borrow
    drive(1'b0, 1'b1, 4'b1000, 4'b0001, 1'b1);   // -8-1 overflow
    drive(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1);   // 0-0 zero
    drive(1'b0, 1'b1, 4'b0000, 4'b1000, 1'b1);   // 0-(-8) overflow
    drive(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b1);   // -8-(-8)

    // Idle with changing operands: outputs must hold.
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    // Back-to-back burst of three.
    drive(1'b0, 1'b1, 4'd6, 4'd1, 1'b0);
    drive(1'b0, 1'b1, 4'd2, 4'd9, 1'b1);
    drive(1'b0, 1'b1, 4'd12, 4'd4, 1'b0);
    drive(1'b0, 1'b0, 4'd1, 4'd1, 1'b0);

    // Mid-stream reset: the operation presented with rst high is dropped.
    drive(1'b0, 1'b1, 4'd4, 4'd3, 1'b0);
    drive(1'b1, 1'b1, 4'd7, 4'd7, 1'b0);
    drive(1'b0, 1'b1, 4'd1, 4'd2, 1'b1);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

    // Random operations, mostly back-to-back with occasional gaps.
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0)
        drive(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
    end

    // Drain so the last result is compared.
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
